// File: rtl/bullet_pkg.sv
// bullet_pkg
//   Shared definitions for the bullet renderer slice:
//   - default screen geometry (SCREEN_WIDTH x SCREEN_HEIGHT),
//   - 3-bit colour codes understood by the VGA adapter,
//   - renderer FSM state encoding,
//   - the pixel record passed down the output pipeline,
//   - a helper deciding whether a widened pixel sum lies on screen.
package bullet_pkg;

  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_BLUE  = 3'b001;
  localparam logic [2:0] COL_WHITE = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ERASE = 2'd1;
  localparam logic [1:0] ST_DRAW  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  // Sums are carried one bit wider than the screen coordinates so that a
  // sprite hanging off the right/bottom edge is clipped instead of wrapping.
  function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy,
                                     input int width, input int height);
    return ({23'd0, sx} < 32'(width)) && ({24'd0, sy} < 32'(height));
  endfunction

endpackage

// File: rtl/bullet_renderer_raster.sv
// sprite_raster_counter
//   Walks a sprite_w x sprite_h box in row-major order, px fastest.
//   Ports:
//     CLOCK_50  in   clock
//     reset     in   synchronous active-high reset
//     start     in   restart at (0,0) on the next edge (wins over advance)
//     advance   in   step to the next pixel on the next edge
//     sprite_w  in   box width  (1..2**PX_BITS)
//     sprite_h  in   box height (1..2**PY_BITS)
//     px, py    out  current raster position
//     last      out  high while the current position is the final pixel
module sprite_raster_counter #(
  parameter int PX_BITS = 3,
  parameter int PY_BITS = 4
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic               advance,
  input  logic [PX_BITS:0]   sprite_w,
  input  logic [PY_BITS:0]   sprite_h,
  output logic [PX_BITS-1:0] px,
  output logic [PY_BITS-1:0] py,
  output logic               last
);

  logic row_end;

  assign row_end = ({1'b0, px} == (sprite_w - {{PX_BITS{1'b0}}, 1'b1}));
  assign last    = row_end && ({1'b0, py} == (sprite_h - {{PY_BITS{1'b0}}, 1'b1}));

  always_ff @(posedge CLOCK_50) begin
    if (reset || start) begin
      px <= '0;
      py <= '0;
    end else if (advance) begin
      if (row_end) begin
        px <= '0;
        py <= last ? '0 : py + 1'b1;
      end else begin
        px <= px + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bullet_renderer.sv
// bullet_renderer
//   Turns the bullet generator's position/active/colour into VGA pixel writes.
//   Whenever the sprite changes, the previously drawn box is erased with
//   BG_COLOR and the new box is drawn, one pixel per clock.
//   Ports:
//     CLOCK_50       in   system clock
//     reset          in   synchronous active-high reset
//     bullet_x/y     in   sprite top-left corner
//     bullet_active  in   sprite visible
//     bullet_color   in   sprite colour
//     vga_x/y/colour out  pixel to the adapter
//     vga_plot       out  write strobe, one cycle per pixel
//     busy           out  high while an update sequence is running
//     frame_done     out  one-cycle pulse after the last pixel of a sequence
module bullet_renderer #(
  parameter int         SCREEN_WIDTH  = bullet_pkg::SCREEN_WIDTH,
  parameter int         SCREEN_HEIGHT = bullet_pkg::SCREEN_HEIGHT,
  parameter int         SPRITE_W      = 4,
  parameter int         SPRITE_H      = 8,
  parameter logic [2:0] BG_COLOR      = bullet_pkg::COL_BLACK
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] bullet_x,
  input  logic [6:0] bullet_y,
  input  logic       bullet_active,
  input  logic [2:0] bullet_color,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       frame_done
);
  import bullet_pkg::*;

  localparam int PX_BITS = 3;
  localparam int PY_BITS = 4;

  logic [1:0] state_reg, state_next;

  // What is currently on screen.
  logic       drawn_valid_reg;
  logic [7:0] drawn_x_reg;
  logic [6:0] drawn_y_reg;
  logic [2:0] drawn_color_reg;

  // Target captured when the change was seen; held for the whole sequence.
  logic       snap_active_reg;
  logic [7:0] snap_x_reg;
  logic [6:0] snap_y_reg;
  logic [2:0] snap_color_reg;

  logic [PX_BITS-1:0] px;
  logic [PY_BITS-1:0] py;
  logic               cnt_last;
  logic               in_raster;
  logic               changed;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  pixel_t     pixel_next;
  pixel_t     issue_reg;
  pixel_t     vga_reg;
  logic       done_issue_reg;
  logic       frame_done_reg;

  assign in_raster = (state_reg == ST_ERASE) || (state_reg == ST_DRAW);

  // Position and colour only matter when both the input and the shadow say
  // the sprite is visible; otherwise only the active flags are compared.
  assign changed = (bullet_active != drawn_valid_reg) ||
                   (bullet_active && drawn_valid_reg &&
                    ({bullet_x, bullet_y, bullet_color} !=
                     {drawn_x_reg, drawn_y_reg, drawn_color_reg}));

  // The counter sits at (0,0) outside ERASE/DRAW and is re-zeroed on the
  // last pixel, so both raster states start from a fresh origin.
  sprite_raster_counter #(
    .PX_BITS (PX_BITS),
    .PY_BITS (PY_BITS)
  ) u_raster (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (!in_raster || cnt_last),
    .advance  (in_raster),
    .sprite_w (4'(SPRITE_W)),
    .sprite_h (5'(SPRITE_H)),
    .px       (px),
    .py       (py),
    .last     (cnt_last)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (changed) begin
          if (drawn_valid_reg)    state_next = ST_ERASE;
          else if (bullet_active) state_next = ST_DRAW;
        end
      end
      ST_ERASE: if (cnt_last) state_next = snap_active_reg ? ST_DRAW : ST_DONE;
      ST_DRAW:  if (cnt_last) state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      drawn_valid_reg <= 1'b0;
      drawn_x_reg     <= '0;
      drawn_y_reg     <= '0;
      drawn_color_reg <= '0;
      snap_active_reg <= 1'b0;
      snap_x_reg      <= '0;
      snap_y_reg      <= '0;
      snap_color_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && changed) begin
        snap_active_reg <= bullet_active;
        snap_x_reg      <= bullet_x;
        snap_y_reg      <= bullet_y;
        snap_color_reg  <= bullet_color;
      end
      if (state_reg == ST_ERASE && cnt_last) begin
        drawn_valid_reg <= 1'b0;
      end
      if (state_reg == ST_DRAW && cnt_last) begin
        drawn_valid_reg <= 1'b1;
        drawn_x_reg     <= snap_x_reg;
        drawn_y_reg     <= snap_y_reg;
        drawn_color_reg <= snap_color_reg;
      end
    end
  end

  // Pixel for the current raster position; off-screen pixels keep their
  // cycle but do not strobe.
  always_comb begin
    base_x            = drawn_x_reg;
    base_y            = drawn_y_reg;
    pixel_next.colour = BG_COLOR;
    if (state_reg == ST_DRAW) begin
      base_x            = snap_x_reg;
      base_y            = snap_y_reg;
      pixel_next.colour = snap_color_reg;
    end
    sum_x           = {1'b0, base_x} + {6'd0, px};
    sum_y           = {1'b0, base_y} + {4'd0, py};
    pixel_next.x    = sum_x[7:0];
    pixel_next.y    = sum_y[6:0];
    pixel_next.plot = in_raster && on_screen(sum_x, sum_y, SCREEN_WIDTH, SCREEN_HEIGHT);
  end

  // Two-stage output pipeline: issue register, then the VGA-facing register.
  // frame_done travels the same depth so it lands right after the last pixel.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      issue_reg      <= '0;
      vga_reg        <= '0;
      done_issue_reg <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      issue_reg      <= pixel_next;
      vga_reg        <= issue_reg;
      done_issue_reg <= (state_reg == ST_DONE);
      frame_done_reg <= done_issue_reg;
    end
  end

  assign vga_x      = vga_reg.x;
  assign vga_y      = vga_reg.y;
  assign vga_colour = vga_reg.colour;
  assign vga_plot   = vga_reg.plot;
  assign frame_done = frame_done_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_bullet_renderer.sv
// Testbench for bullet_renderer: a sequence-level model schedules the
// expected pixel stream per cycle; directed scenarios plus random stimulus.
module tb_bullet_renderer;

  localparam int SW    = 4;
  localparam int SH    = 8;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int RING  = 256;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] bullet_x = 8'd0;
  logic [6:0] bullet_y = 7'd0;
  logic       bullet_active = 1'b0;
  logic [2:0] bullet_color = 3'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       frame_done;

  always #10 CLOCK_50 = ~CLOCK_50;

  bullet_renderer #(
    .SCREEN_WIDTH  (SCR_W),
    .SCREEN_HEIGHT (SCR_H),
    .SPRITE_W      (SW),
    .SPRITE_H      (SH),
    .BG_COLOR      (3'b000)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .bullet_color  (bullet_color),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .vga_plot      (vga_plot),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected output for the cycle following each edge, indexed cycle % RING.
  bit exp_plot [RING];
  int exp_x    [RING];
  int exp_y    [RING];
  int exp_c    [RING];
  bit exp_done [RING];

  // What the model believes is on screen and when it next compares.
  bit m_valid;
  int m_x, m_y, m_c;
  int next_cmp;
  int busy_last;

  // Per-phase statistics for the hand-computed checks.
  int n_plot, n_done, n_busy, n_c0;
  int first_x, first_y, first_c, last_x, last_y, last_c;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic put_box(input int t0, input int bx, input int by, input int col);
    for (int i = 0; i < SW * SH; i++) begin
      int sx;
      int sy;
      int s;
      sx = bx + (i % SW);
      sy = by + (i / SW);
      s  = (t0 + i) % RING;
      exp_plot[s] = (sx < SCR_W) && (sy < SCR_H);
      exp_x[s]    = sx;
      exp_y[s]    = sy;
      exp_c[s]    = col;
    end
  endtask

  // Applied at each rising edge with the inputs the DUT is sampling.
  task automatic model_edge();
    int  k;
    bit  diff;
    if (reset) begin
      for (int i = 0; i < RING; i++) begin
        exp_plot[i] = 1'b0;
        exp_done[i] = 1'b0;
      end
      m_valid   = 1'b0;
      m_x       = 0;
      m_y       = 0;
      m_c       = 0;
      next_cmp  = cyc + 1;
      busy_last = cyc - 1;
    end else if (cyc >= next_cmp) begin
      diff = (bullet_active != m_valid) ||
             (bullet_active && (int'(bullet_x) != m_x || int'(bullet_y) != m_y ||
                                int'(bullet_color) != m_c));
      if (diff) begin
        k = 0;
        if (m_valid) begin
          put_box(cyc + 2, m_x, m_y, 0);
          k = SW * SH;
          m_valid = 1'b0;
        end
        if (bullet_active) begin
          put_box(cyc + 2 + k, int'(bullet_x), int'(bullet_y), int'(bullet_color));
          k += SW * SH;
          m_valid = 1'b1;
          m_x = int'(bullet_x);
          m_y = int'(bullet_y);
          m_c = int'(bullet_color);
        end
        exp_done[(cyc + k + 2) % RING] = 1'b1;
        busy_last = cyc + k;
        next_cmp  = cyc + k + 2;
      end
    end
  endtask

  task automatic clear_stats();
    n_plot = 0; n_done = 0; n_busy = 0; n_c0 = 0;
    first_x = -1; first_y = -1; first_c = -1;
    last_x = -1; last_y = -1; last_c = -1;
  endtask

  task automatic step();
    bit was_reset;
    int s;
    @(posedge CLOCK_50);
    cyc++;
    was_reset = reset;
    model_edge();
    @(negedge CLOCK_50);
    s = cyc % RING;
    chk("busy", int'(busy), int'(cyc <= busy_last));
    chk("vga_plot", int'(vga_plot), int'(exp_plot[s]));
    chk("frame_done", int'(frame_done), int'(exp_done[s]));
    if (exp_plot[s] && vga_plot) begin
      chk("vga_x", int'(vga_x), exp_x[s]);
      chk("vga_y", int'(vga_y), exp_y[s]);
      chk("vga_colour", int'(vga_colour), exp_c[s]);
    end
    if (was_reset) begin
      chk("reset_vga_x", int'(vga_x), 0);
      chk("reset_vga_y", int'(vga_y), 0);
      chk("reset_vga_colour", int'(vga_colour), 0);
    end
    if (vga_plot) begin
      if (n_plot == 0) begin
        first_x = int'(vga_x); first_y = int'(vga_y); first_c = int'(vga_colour);
      end
      last_x = int'(vga_x); last_y = int'(vga_y); last_c = int'(vga_colour);
      n_plot++;
      if (vga_colour == 3'd0) n_c0++;
    end
    if (frame_done) n_done++;
    if (busy) n_busy++;
    exp_plot[s] = 1'b0;
    exp_done[s] = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    clear_stats();

    // Reset held three cycles.
    reset = 1'b1;
    steps(3);
    chk("reset_busy_cnt", n_busy, 0);
    chk("reset_plot_cnt", n_plot, 0);

    // Spawn at (71,0) colour 001: draw only.
    reset = 1'b0;
    bullet_x = 8'd71; bullet_y = 7'd0; bullet_color = 3'b001; bullet_active = 1'b1;
    clear_stats();
    steps(40);
    chk("spawn_plots", n_plot, 32);
    chk("spawn_done", n_done, 1);
    chk("spawn_first_x", first_x, 71);
    chk("spawn_first_y", first_y, 0);
    chk("spawn_first_c", first_c, 1);
    chk("spawn_last_x", last_x, 74);
    chk("spawn_last_y", last_y, 7);
    chk("spawn_erase_cnt", n_c0, 0);

    // Move down one row: erase then redraw.
    bullet_y = 7'd1;
    clear_stats();
    steps(72);
    chk("move_plots", n_plot, 64);
    chk("move_erase_cnt", n_c0, 32);
    chk("move_done", n_done, 1);
    chk("move_first_c", first_c, 0);
    chk("move_first_y", first_y, 0);
    chk("move_last_x", last_x, 74);
    chk("move_last_y", last_y, 8);
    chk("move_last_c", last_c, 1);

    // Deactivate: erase only.
    bullet_active = 1'b0;
    clear_stats();
    steps(40);
    chk("hide_plots", n_plot, 32);
    chk("hide_erase_cnt", n_c0, 32);
    chk("hide_done", n_done, 1);
    chk("hide_last_y", last_y, 8);

    // Spawn near the bottom edge: rows 120..122 are clipped.
    bullet_y = 7'd115; bullet_active = 1'b1;
    clear_stats();
    steps(40);
    chk("clip_plots", n_plot, 20);
    chk("clip_busy_cycles", n_busy, 33);
    chk("clip_first_y", first_y, 115);
    chk("clip_last_x", last_x, 74);
    chk("clip_last_y", last_y, 119);
    chk("clip_done", n_done, 1);

    // Pure colour change, then move x while that redraw is in DRAW.
    bullet_color = 3'b111;
    clear_stats();
    steps(45);
    bullet_x = 8'd81;
    steps(110);
    chk("midmove_plots", n_plot, 80);
    chk("midmove_erase_cnt", n_c0, 40);
    chk("midmove_done", n_done, 2);
    chk("midmove_last_x", last_x, 84);
    chk("midmove_last_c", last_c, 7);

    // Reset in the middle of an erase.
    bullet_y = 7'd60;
    steps(6);
    chk("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_plot", int'(vga_plot), 0);
    reset = 1'b0;
    clear_stats();
    steps(40);
    chk("after_reset_plots", n_plot, 32);
    chk("after_reset_erase_cnt", n_c0, 0);
    chk("after_reset_first_x", first_x, 81);
    chk("after_reset_first_y", first_y, 60);
    chk("after_reset_done", n_done, 1);

    // Random stimulus with edge-heavy coordinates and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      reset = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: bullet_x = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(150, 165))
                                                    : 8'($urandom_range(0, 255));
          1: bullet_y = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(108, 127))
                                                    : 7'($urandom_range(0, 127));
          2: bullet_color = 3'($urandom_range(0, 7));
          default: bullet_active = ~bullet_active;
        endcase
      end
      if ($urandom_range(0, 499) == 0) reset = 1'b1;
      step();
    end
    reset = 1'b0;
    steps(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
